// File: rtl/clq_pkg.sv
// Shared clause-queue types and constants, imported by the CLQ and by clq_walker.
// Node index NULL_PTR (all ones, i.e. DEPTH-1) is never allocated and terminates a list.
package clq_pkg;
  localparam int CLQ_DEPTH   = 16;
  localparam int PTR_W       = $clog2(CLQ_DEPTH);
  localparam int LIT_IDX_W   = 8;
  localparam int LIT_IDX_MAX = (1 << (LIT_IDX_W - 1)) - 1;

  typedef logic [PTR_W-1:0] ptr_t;

  // Literal: polarity bit plus a two's-complement variable index.
  typedef struct packed {
    logic                        sign;
    logic signed [LIT_IDX_W-1:0] idx;
  } lit_t;

  typedef struct packed {
    lit_t lit_a;
    lit_t lit_b;
    ptr_t next;
  } node_t;

  localparam ptr_t NULL_PTR = '1;

  // One dummy list head per literal, addressed by {idx, sign}.
  typedef logic [LIT_IDX_W:0] dummy_ptr_t;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_FETCH = 3'd2;
  localparam logic [2:0] ST_EMIT  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  function automatic dummy_ptr_t lit2dummy(input lit_t l);
    return {l.idx, l.sign};
  endfunction
endpackage

// File: rtl/clq_walker.sv
// BCP-side CLQ reader: looks up a literal's list head, then streams each linked node to the evaluator.
// Optional hop-limit loop guard enabled by defining CLQ_LOOP_GUARD_EN.
module clq_walker
  import clq_pkg::*;
#(
  parameter int DEPTH    = CLQ_DEPTH,
  parameter int MAX_HOPS = DEPTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  lit_t                    uc_lit_in,
  input  logic                    uc_valid,
  output logic                    uc_ready,
  output lit_t                    walk2clq_uc_rqst,
  output logic                    walk2clq_uc_rqst_valid,
  input  ptr_t                    clq2walk_init_ptr,
  input  logic                    clq2walk_init_ptr_valid,
  output ptr_t                    walk2clq_cnf_idx,
  input  node_t                   clq2walk_node,
  output node_t                   node_out,
  output logic                    node_out_valid,
  input  logic                    node_out_ready,
  output logic                    walk_done,
  output logic [$clog2(DEPTH):0]  walk_count,
  output logic                    walk_err,
  output logic [2:0]              dbg_state
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] HOP_LIMIT = CW'(MAX_HOPS);

`ifdef CLQ_LOOP_GUARD_EN
  localparam logic GUARD_EN = 1'b1;
`else
  localparam logic GUARD_EN = 1'b0;
`endif

  logic [2:0]    r_state;
  lit_t          r_lit_q;
  ptr_t          r_cur_ptr;
  node_t         r_node_q;
  logic [CW-1:0] r_walk_count;
  logic          r_walk_err;

  logic [CW-1:0] w_count_nxt;
  logic          w_hop_trip;

  assign w_count_nxt = r_walk_count + 1'b1;
  // The node just accepted is the last one allowed, yet the list continues.
  assign w_hop_trip  = GUARD_EN && (w_count_nxt == HOP_LIMIT);

  // Both streams use valid/ready: a transfer happens in a cycle where valid and ready are both
  // high; valid and its payload stay stable until that cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_lit_q      <= '0;
      r_cur_ptr    <= '0;
      r_node_q     <= '0;
      r_walk_count <= '0;
      r_walk_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (uc_valid) begin
            r_lit_q      <= uc_lit_in;
            r_walk_count <= '0;
            r_walk_err   <= 1'b0;
            r_state      <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (clq2walk_init_ptr_valid) begin
            if (clq2walk_init_ptr == NULL_PTR) begin
              r_state <= ST_DONE;
            end else begin
              r_cur_ptr <= clq2walk_init_ptr;
              r_state   <= ST_FETCH;
            end
          end
        end
        ST_FETCH: begin
          r_node_q <= clq2walk_node;
          r_state  <= ST_EMIT;
        end
        ST_EMIT: begin
          if (node_out_ready) begin
            r_walk_count <= w_count_nxt;
            if (r_node_q.next == NULL_PTR) begin
              r_state <= ST_DONE;
            end else if (w_hop_trip) begin
              r_walk_err <= 1'b1;
              r_state    <= ST_DONE;
            end else begin
              r_cur_ptr <= r_node_q.next;
              r_state   <= ST_FETCH;
            end
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign uc_ready               = (r_state == ST_IDLE);
  assign walk2clq_uc_rqst       = (r_state == ST_REQ) ? r_lit_q : '0;
  assign walk2clq_uc_rqst_valid = (r_state == ST_REQ);
  assign walk2clq_cnf_idx       = (r_state == ST_FETCH) ? r_cur_ptr : '0;
  assign node_out               = (r_state == ST_EMIT) ? r_node_q : '0;
  assign node_out_valid         = (r_state == ST_EMIT);
  assign walk_done              = (r_state == ST_DONE);
  assign walk_count             = r_walk_count;
  assign walk_err               = r_walk_err & GUARD_EN;
  assign dbg_state              = r_state;
endmodule

// File: tb/tb_clq_walker.sv
// Bench for clq_walker: table-driven walks, hand-written corner sequences, and random walks
// checked against a list-following reference model. Build with CLQ_LOOP_GUARD_EN for the guard case.
module tb_clq_walker;
  import clq_pkg::*;

  localparam int DEPTH   = CLQ_DEPTH;
  localparam int CW      = $clog2(DEPTH) + 1;
  localparam int NW      = $bits(node_t);
  localparam int HOPS_TB = 4;
  localparam int BUDGET  = 160;
`ifdef CLQ_LOOP_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  lit_t          uc_lit_in;
  logic          uc_valid;
  logic          uc_ready;
  lit_t          walk2clq_uc_rqst;
  logic          walk2clq_uc_rqst_valid;
  ptr_t          clq2walk_init_ptr;
  logic          clq2walk_init_ptr_valid;
  ptr_t          walk2clq_cnf_idx;
  node_t         clq2walk_node;
  node_t         node_out;
  logic          node_out_valid;
  logic          node_out_ready;
  logic          walk_done;
  logic [CW-1:0] walk_count;
  logic          walk_err;
  logic [2:0]    dbg_state;

  // ---------------- clock / CLQ model ----------------
  always #5 clk = ~clk;

  node_t mem [DEPTH];
  ptr_t  head;
  logic  head_vld_en;
  assign clq2walk_node           = mem[walk2clq_cnf_idx];
  assign clq2walk_init_ptr       = head;
  assign clq2walk_init_ptr_valid = head_vld_en;

  clq_walker #(.DEPTH(DEPTH), .MAX_HOPS(HOPS_TB)) dut (
    .clk(clk), .rst_n(rst_n),
    .uc_lit_in(uc_lit_in), .uc_valid(uc_valid), .uc_ready(uc_ready),
    .walk2clq_uc_rqst(walk2clq_uc_rqst), .walk2clq_uc_rqst_valid(walk2clq_uc_rqst_valid),
    .clq2walk_init_ptr(clq2walk_init_ptr), .clq2walk_init_ptr_valid(clq2walk_init_ptr_valid),
    .walk2clq_cnf_idx(walk2clq_cnf_idx), .clq2walk_node(clq2walk_node),
    .node_out(node_out), .node_out_valid(node_out_valid), .node_out_ready(node_out_ready),
    .walk_done(walk_done), .walk_count(walk_count), .walk_err(walk_err), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_tests;
  int n_fail;
  logic [NW-1:0] exp_q[$];
  int hs_rel[$];
  int chain[$];
  int done_rel;
  int st_at  [BUDGET];
  int idx_at [BUDGET];
  int cnt_at [BUDGET];
  int rv_at  [BUDGET];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic lit_t mk_lit(input int v);
    lit_t l;
    l.sign = (v < 0);
    l.idx  = LIT_IDX_W'((v < 0) ? -v : v);
    return l;
  endfunction

  function automatic lit_t rand_lit();
    lit_t l;
    l.sign = 1'($urandom_range(1));
    l.idx  = LIT_IDX_W'($urandom_range(LIT_IDX_MAX));
    return l;
  endfunction

  task automatic fill_mem();
    for (int i = 0; i < DEPTH; i++) begin
      mem[i].lit_a = rand_lit();
      mem[i].lit_b = rand_lit();
      mem[i].next  = ptr_t'($urandom_range(DEPTH - 1));
    end
  endtask

  // Link the nodes listed in chain[] in order; returns the list head.
  task automatic link_chain(output ptr_t h);
    h = (chain.size() == 0) ? NULL_PTR : ptr_t'(chain[0]);
    for (int i = 0; i < chain.size(); i++)
      mem[chain[i]].next = (i == chain.size() - 1) ? NULL_PTR : ptr_t'(chain[i + 1]);
  endtask

  // Reference: follow next pointers from the head; with the guard, a walk that has emitted
  // HOPS_TB nodes while more remain stops with an error.
  task automatic build_expect(input ptr_t h, output int n, output logic err);
    ptr_t p;
    p = h; n = 0; err = 1'b0;
    exp_q.delete();
    while (p != NULL_PTR && n < 64) begin
      exp_q.push_back(mem[p]);
      n++;
      if (GUARD && n == HOPS_TB && mem[p].next != NULL_PTR) begin
        err = 1'b1;
        break;
      end
      p = mem[p].next;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; uc_valid = 1'b0; node_out_ready = 1'b0; head_vld_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drive one walk starting at relative cycle 0 and score it until walk_done.
  task automatic run_walk(input lit_t lit, input ptr_t h, input int vld_delay, input int rdy_pct,
                          input int lo_s, input int lo_n, input bit noise);
    int exp_n, done_cnt;
    logic exp_err, bad_ready, bad_rqst, bad_stable, prev_stall;
    node_t prev;
    head = h;
    build_expect(h, exp_n, exp_err);
    hs_rel.delete();
    done_rel = -1; done_cnt = 0;
    bad_ready = 0; bad_rqst = 0; bad_stable = 0; prev_stall = 0; prev = '0;
    for (int rel = 0; rel < BUDGET; rel++) begin
      @(negedge clk);
      uc_lit_in   = (rel == 0 || !noise) ? lit : rand_lit();
      uc_valid    = (rel == 0) || (noise && $urandom_range(1) == 1);
      head_vld_en = (rel >= 1 + vld_delay);
      if (rel >= lo_s && rel < lo_s + lo_n) node_out_ready = 1'b0;
      else node_out_ready = ($urandom_range(99) < rdy_pct);
      #1;
      st_at[rel] = dbg_state; idx_at[rel] = walk2clq_cnf_idx;
      cnt_at[rel] = walk_count; rv_at[rel] = walk2clq_uc_rqst_valid;
      if (rel > 0 && uc_ready) bad_ready = 1;
      if (walk2clq_uc_rqst_valid && walk2clq_uc_rqst !== lit) bad_rqst = 1;
      if (node_out_valid && prev_stall && node_out !== prev) bad_stable = 1;
      prev_stall = node_out_valid && !node_out_ready;
      prev = node_out;
      if (node_out_valid && node_out_ready) begin
        hs_rel.push_back(rel);
        if (exp_q.size() == 0) check("extra_node", 1, 0);
        else check("node_data", node_out, exp_q.pop_front());
      end
      if (walk_done) begin
        done_cnt++;
        done_rel = rel;
        break;
      end
    end
    @(negedge clk);
    uc_valid = 1'b0;
    #1;
    check("walk_done_once", done_cnt, 1);
    check("nodes_missing", exp_q.size(), 0);
    check("uc_ready_busy", bad_ready, 0);
    check("rqst_lit", bad_rqst, 0);
    check("node_stable", bad_stable, 0);
    check("done_single_pulse", walk_done, 0);
    check("idle_after_done", uc_ready, 1);
    check("walk_count", walk_count, CW'(exp_n));
    check("walk_err", walk_err, exp_err);
  endtask

  // ---------------- table ----------------
  typedef struct {
    int lit;
    int n;
    int p0, p1, p2, p3;
    int done;
    int count;
  } vec_t;
  vec_t vecs [4];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    ptr_t h;
    int perm [DEPTH - 1];
    int len, nhs;

    n_tests = 0; n_fail = 0;
    rst_n = 1'b0; uc_valid = 1'b0; uc_lit_in = '0; node_out_ready = 1'b0;
    head_vld_en = 1'b0; head = NULL_PTR;
    fill_mem();

    vecs[0] = '{lit:  3, n: 0, p0:  0, p1:  0, p2: 0, p3: 0, done:  2, count: 0};
    vecs[1] = '{lit: -4, n: 3, p0:  2, p1:  5, p2: 9, p3: 0, done:  8, count: 3};
    vecs[2] = '{lit:  7, n: 1, p0:  0, p1:  0, p2: 0, p3: 0, done:  4, count: 1};
    vecs[3] = '{lit: -1, n: 4, p0: 14, p1: 13, p2: 0, p3: 6, done: 10, count: 4};

    // reset state
    @(negedge clk); @(negedge clk); #1;
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_uc_ready", uc_ready, 1);
    check("rst_rqst_valid", walk2clq_uc_rqst_valid, 0);
    check("rst_rqst", walk2clq_uc_rqst, 0);
    check("rst_cnf_idx", walk2clq_cnf_idx, 0);
    check("rst_node_valid", node_out_valid, 0);
    check("rst_node_out", node_out, 0);
    check("rst_walk_done", walk_done, 0);
    check("rst_walk_count", walk_count, 0);
    check("rst_walk_err", walk_err, 0);
    rst_n = 1'b1;

    // table-driven walks, ready held high
    for (int v = 0; v < 4; v++) begin
      chain.delete();
      if (vecs[v].n > 0) chain.push_back(vecs[v].p0);
      if (vecs[v].n > 1) chain.push_back(vecs[v].p1);
      if (vecs[v].n > 2) chain.push_back(vecs[v].p2);
      if (vecs[v].n > 3) chain.push_back(vecs[v].p3);
      link_chain(h);
      run_walk(mk_lit(vecs[v].lit), h, 0, 100, -1, 0, 0);
      check("tbl_done_cycle", done_rel, vecs[v].done);
      check("tbl_count", walk_count, vecs[v].count);
      check("tbl_hs_n", hs_rel.size(), vecs[v].n);
      nhs = (hs_rel.size() < vecs[v].n) ? hs_rel.size() : vecs[v].n;
      for (int i = 0; i < nhs; i++) begin
        check("tbl_node_cycle", hs_rel[i], 3 + 2 * i);
        check("tbl_fetch_idx", idx_at[2 + 2 * i], chain[i]);
      end
      check("tbl_rqst_valid_c1", rv_at[1], 1);
    end

    // backpressure on node 5 for four cycles
    chain = '{2, 5, 9};
    link_chain(h);
    run_walk(mk_lit(-4), h, 0, 100, 5, 4, 0);
    check("bp_hs_n", hs_rel.size(), 3);
    if (hs_rel.size() == 3) begin
      check("bp_hs0", hs_rel[0], 3);
      check("bp_hs1", hs_rel[1], 9);
      check("bp_hs2", hs_rel[2], 11);
    end
    check("bp_done", done_rel, 12);
    for (int r = 5; r <= 9; r++) begin
      check("bp_count_hold", cnt_at[r], 1);
      check("bp_idx_hold", idx_at[r], 0);
      check("bp_state", st_at[r], ST_EMIT);
    end
    check("bp_count_inc", cnt_at[10], 2);
    check("bp_fetch_next", idx_at[10], 9);

    // head pointer valid withheld for three REQ cycles
    run_walk(mk_lit(11), h, 3, 100, -1, 0, 0);
    for (int r = 1; r <= 4; r++) begin
      check("req_hold_state", st_at[r], ST_REQ);
      check("req_hold_valid", rv_at[r], 1);
    end
    check("req_to_fetch", st_at[5], ST_FETCH);
    check("req_first_node", (hs_rel.size() > 0) ? hs_rel[0] : -1, 6);
    check("req_done", done_rel, 11);

    // reset while node 5 is being offered
    @(negedge clk);
    uc_lit_in = mk_lit(-4); uc_valid = 1'b1; node_out_ready = 1'b1; head_vld_en = 1'b1; head = h;
    for (int r = 1; r <= 5; r++) begin
      @(negedge clk);
      uc_valid = 1'b0;
      if (r == 5) node_out_ready = 1'b0;
    end
    #1;
    check("rst_mid_valid_before", node_out_valid, 1);
    check("rst_mid_node_before", node_out, mem[5]);
    rst_n = 1'b0;
    @(negedge clk); #1;
    check("rst_mid_state", dbg_state, ST_IDLE);
    check("rst_mid_uc_ready", uc_ready, 1);
    check("rst_mid_node_valid", node_out_valid, 0);
    check("rst_mid_count", walk_count, 0);
    check("rst_mid_done", walk_done, 0);
    rst_n = 1'b1; node_out_ready = 1'b1;
    for (int r = 0; r < 3; r++) begin
      @(negedge clk); #1;
      check("rst_mid_no_done", walk_done, 0);
    end
    run_walk(mk_lit(5), h, 0, 100, -1, 0, 0);
    check("rst_mid_rewalk_done", done_rel, 8);

    // cyclic list 1 -> 3 -> 1
    mem[1].next = 3;
    mem[3].next = 1;
`ifdef CLQ_LOOP_GUARD_EN
    run_walk(mk_lit(2), 1, 0, 100, -1, 0, 0);
    check("guard_hs_n", hs_rel.size(), 4);
    check("guard_done", done_rel, 10);
    check("guard_err", walk_err, 1);
    chain.delete();
    link_chain(h);
    run_walk(mk_lit(2), h, 0, 100, -1, 0, 0);
    check("guard_err_cleared", walk_err, 0);
`else
    @(negedge clk);
    uc_lit_in = mk_lit(2); uc_valid = 1'b1; node_out_ready = 1'b1; head_vld_en = 1'b1; head = 1;
    nhs = 0;
    for (int r = 0; r < 70; r++) begin
      #1;
      if (node_out_valid) nhs++;
      check("cyc_no_done", walk_done, 0);
      @(negedge clk);
      uc_valid = 1'b0;
    end
    #1;
    check("cyc_hs_n", nhs, 34);
    check("cyc_count_wrap", walk_count, CW'(34));
    check("cyc_err_tied", walk_err, 0);
    do_reset();
`endif

    // random walks with random backpressure, head delay and ignored uc_valid noise
    for (int t = 0; t < 30; t++) begin
      fill_mem();
      for (int i = 0; i < DEPTH - 1; i++) perm[i] = i;
      for (int i = DEPTH - 2; i > 0; i--) begin
        int j, tmp;
        j = $urandom_range(i);
        tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
      end
      len = $urandom_range(6);
      chain.delete();
      for (int i = 0; i < len; i++) chain.push_back(perm[i]);
      link_chain(h);
      run_walk(rand_lit(), h, $urandom_range(3), $urandom_range(30, 100), -1, 0, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
